imem_loader: RTL and testbench
==============================

# imem_loader

Hardware program loader for the single-clock MIPS core. It accepts a byte stream carrying a length-prefixed program image and writes it word by word into instruction memory starting at address 0. It holds the CPU in reset (`pcclr` low) while loading and releases it once the final word is committed. It watches the CPU's `fin` flag so a new image can be loaded after the program ends. It sits between an external byte source (UART/host bridge) and the `insmem` write port, driving the same `pcclr` the core already consumes.

## Interface
- `ADDR_W`, 8 — instruction memory word-address width; depth = 2^ADDR_W words.
- `clk`  in  1  — system clock; all state changes on its rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `in_valid`  in  1  — byte source has a byte on `in_data`.
- `in_data`  in  8  — stream byte.
- `in_ready`  out  1  — loader accepts the byte this cycle.
- `wr_en`  out  1  — one-cycle instruction-memory write strobe.
- `wr_addr`  out  ADDR_W  — word address to write.
- `wr_data`  out  32  — instruction word to write.
- `pcclr`  out  1  — CPU run enable; 0 holds the CPU in reset, 1 runs it.
- `fin`  in  1  — CPU program-finished flag.
- `done`  out  1  — sticky: the program has finished since the last load.
- `err`  out  1  — sticky: the length field exceeded the memory depth.

## Operation
- Stream format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4·N bytes, each word big-endian (first byte goes to bits 31:24).
- Handshake: a byte transfers on a rising edge with `in_valid & in_ready`. `in_data` is ignored otherwise. `in_valid` may drop at any time with no effect.
- State machine:
  - LEN_HI: `in_ready`=1; on transfer, store the high byte → LEN_LO.
  - LEN_LO: `in_ready`=1; on transfer, form N.
    - N=0 → RUN.
    - N>2^ADDR_W → ERR.
    - Otherwise → DATA, with byte index 0 and address 0.
  - DATA: `in_ready`=1; shift bytes into the packer. On the 4th byte:
    - issue the write next cycle;
    - increment the address and decrement the remaining count (mod-4 index wraps to 0).
    - After the N-th word's write cycle → RUN.
  - RUN: `in_ready`=0, `pcclr`=1. A rising edge of `fin` (fin=1, previous sample 0) sets `done` → DONE.
  - DONE: `pcclr`=1, `in_ready`=1. The first accepted byte is LEN_HI of a new image: `pcclr`→0, `done`→0 → LEN_LO.
  - ERR: `in_ready`=0, `pcclr`=0, `err`=1. Only `rst` leaves this state.
- Boundary conditions:
  - N exactly 2^ADDR_W is legal; the address wraps to 0 after the last word but is not used again.
  - `fin` outside RUN is ignored.
  - A new load never clears `err`.
- Reset, asynchronous and taking effect at any point including mid-load:
  - state LEN_HI; `pcclr`=0, `in_ready`=0 while `rst` is high, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `done`=0, `err`=0; counters and packer cleared.
  - A partially written image is abandoned; no further write is issued.

## Timing
- All outputs are registered; `in_ready` is decoded from registered state only and never depends on `in_valid`.
- Write latency: the 4th byte is accepted at edge k; `wr_en`=1 with valid `wr_addr`/`wr_data` during cycle k→k+1, and low after edge k+1.
- `pcclr` rises at the edge after the final `wr_en` cycle, so the last word is committed before the CPU leaves reset. For N=0, `pcclr` rises at the edge after LEN_LO is accepted.
- Throughput: one byte per cycle sustained, i.e. one word per 4 cycles. Back-to-back words produce `wr_en` pulses 4 cycles apart.
- `fin` is sampled on each edge. `done` sets on the edge where the rising edge of `fin` is detected, i.e. one cycle after `fin` goes high.

## Structure
- Shared header `mipsdefs.vh`: the state encodings (LEN_HI, LEN_LO, DATA, RUN, DONE, ERR), `WORD_W`=32, and the default `ADDR_W`.
- Sub-module `byte_packer`: a 4-byte shift register with a 2-bit index. It outputs the 32-bit word and a `word_ready` pulse. The top level holds the FSM, the address/count counters, `fin` edge detection and the output registers.

## Test plan
- Load N=3 (bytes 00 03, then 20080005 20090007 01095020), stream continuous → writes to addr 0,1,2 with those words; `pcclr` goes 1 one cycle after the 3rd `wr_en`.
- Same image with `in_valid` toggled every other cycle → identical writes, `wr_en` pulses 8 cycles apart, no extra or duplicate writes.
- N=0 (00 00) → no `wr_en`; `pcclr`=1 the cycle after the second byte.
- With ADDR_W=8, N=0x0101 → `err`=1, `in_ready`=0, `pcclr` stays 0 regardless of further `in_valid`; a `rst` pulse clears `err` and returns to LEN_HI.
- Assert `rst` after 6 data bytes of an N=2 load → all outputs return to reset values immediately; the following full reload writes addr 0 and 1 correctly.
- After RUN, pulse `fin`=1 → `done`=1 the next cycle; send a new 1-word image → `pcclr`/`done` drop on the first byte, one write to addr 0, `pcclr` returns to 1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

  localparam int WORD_W         = 32;
  localparam int LEN_W          = 16;
  localparam int DEFAULT_ADDR_W = 8;

  typedef enum logic [2:0] {
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_RUN,
    ST_DONE,
    ST_ERR
  } state_e;

  // States in which the loader is willing to take a byte from the stream.
  function automatic logic accepts_bytes(input state_e s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Collects four stream bytes, most significant first, into one 32-bit word.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_ready
);

  logic [23:0] shreg_q, shreg_d;
  logic [1:0]  idx_q, idx_d;

  // The word is presented as the byte arriving now completes it, so the
  // parent can register it on the same edge that accepts the 4th byte.
  assign word       = {shreg_q, byte_in};
  assign word_ready = byte_en && (idx_q == 2'd3);

  // Shift in each accepted byte; the index wraps naturally after four bytes.
  always_comb begin
    shreg_d = shreg_q;
    idx_d   = idx_q;
    if (clear) begin
      shreg_d = '0;
      idx_d   = '0;
    end else if (byte_en) begin
      shreg_d = {shreg_q[15:0], byte_in};
      idx_d   = idx_q + 2'd1;
    end
  end

  // Packer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      idx_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory and holds the
// CPU in reset (pcclr low) until the last word has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              pcclr,
  input  logic              fin,
  output logic              done,
  output logic              err
);

  localparam int unsigned MAX_WORDS = 32'd1 << ADDR_W;

  state_e              state_q, state_d;
  logic [7:0]          len_hi_q, len_hi_d;
  logic [LEN_W-1:0]    remaining_q, remaining_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0]   wr_data_q, wr_data_d;
  logic                wr_en_q, wr_en_d;
  logic                in_ready_q, in_ready_d;
  logic                pcclr_q, pcclr_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                fin_prev_q, fin_prev_d;

  logic                xfer;
  logic [LEN_W-1:0]    len_word;
  logic                len_too_long;
  logic [WORD_W-1:0]   pack_word;
  logic                pack_ready;

  assign xfer         = in_valid && in_ready_q;
  assign len_word     = {len_hi_q, in_data};
  assign len_too_long = 32'(len_word) > MAX_WORDS;

  imem_loader_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (xfer && (state_q == ST_LEN_LO)),
    .byte_en    (xfer && (state_q == ST_DATA)),
    .byte_in    (in_data),
    .word       (pack_word),
    .word_ready (pack_ready)
  );

  // Next-state logic; pcclr follows the state one edge late so the final
  // write strobe is always complete before the CPU is released.
  always_comb begin
    state_d     = state_q;
    len_hi_d    = len_hi_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    pcclr_d     = pcclr_q;
    done_d      = done_q;
    err_d       = err_q;
    fin_prev_d  = fin;
    case (state_q)
      ST_LEN_HI: begin
        if (xfer) begin
          len_hi_d = in_data;
          state_d  = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (xfer) begin
          if (len_word == '0) begin
            state_d = ST_RUN;
          end else if (len_too_long) begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end else begin
            remaining_d = len_word;
            addr_d      = '0;
            state_d     = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (pack_ready) begin
          wr_en_d     = 1'b1;
          wr_addr_d   = addr_q;
          wr_data_d   = pack_word;
          addr_d      = addr_q + ADDR_W'(1);
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        pcclr_d = 1'b1;
        if (fin && !fin_prev_q) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        pcclr_d = 1'b1;
        if (xfer) begin
          pcclr_d  = 1'b0;
          done_d   = 1'b0;
          len_hi_d = in_data;
          state_d  = ST_LEN_LO;
        end
      end
      ST_ERR: begin
        pcclr_d = 1'b0;
        err_d   = 1'b1;
      end
      default: begin
        state_d = ST_LEN_HI;
      end
    endcase
    in_ready_d = accepts_bytes(state_d);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_LEN_HI;
      len_hi_q    <= '0;
      remaining_q <= '0;
      addr_q      <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      pcclr_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      fin_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_hi_q    <= len_hi_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      in_ready_q  <= in_ready_d;
      pcclr_q     <= pcclr_d;
      done_q      <= done_d;
      err_q       <= err_d;
      fin_prev_q  <= fin_prev_d;
    end
  end

  assign in_ready = in_ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign pcclr    = pcclr_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard.
module tb_imem_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              pcclr;
  logic              fin;
  logic              done;
  logic              err;

  int checks      = 0;
  int failures    = 0;
  int cycle_count = 0;

  logic [ADDR_W+31:0] exp_q[$];
  int                 wr_cycles[$];
  logic [ADDR_W-1:0]  next_addr;

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .pcclr    (pcclr),
    .fin      (fin),
    .done     (done),
    .err      (err)
  );

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Cycle counter used to measure spacing between write strobes.
  always @(posedge clk) cycle_count <= cycle_count + 1;

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    logic [ADDR_W+31:0] e;
    if (rst === 1'b0 && wr_en === 1'b1) begin
      wr_cycles.push_back(cycle_count);
      if (exp_q.size() == 0) begin
        check_output("unexpected_write", 32'(wr_en), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_output("wr_addr", 32'(wr_addr), 32'(e[ADDR_W+31:32]));
        check_output("wr_data", wr_data, e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte and wait (bounded) for the edge that transfers it.
  task automatic apply_stimulus(input logic [7:0] b);
    bit sent;
    sent     = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 20 && !sent; i++) begin
      if (in_ready === 1'b1) sent = 1'b1;
      tick();
    end
    if (!sent) check_output("byte_accept_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic idle_gap();
    in_valid = 1'b0;
    in_data  = 8'h5A;
    tick();
  endtask

  task automatic send_header(input logic [15:0] n, input bit slow);
    apply_stimulus(n[15:8]);
    if (slow) idle_gap();
    apply_stimulus(n[7:0]);
    if (slow) idle_gap();
    next_addr = '0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit slow);
    exp_q.push_back({next_addr, w});
    next_addr = next_addr + ADDR_W'(1);
    for (int b = 0; b < 4; b++) begin
      apply_stimulus(w[31-8*b -: 8]);
      if (b == 3) check_output("wr_en_after_4th_byte", 32'(wr_en), 32'd1);
      if (slow) idle_gap();
    end
  endtask

  task automatic pulse_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic check_gaps(input string tag, input int n, input int gap);
    check_output({tag, "_count"}, 32'(wr_cycles.size()), 32'(n));
    if (wr_cycles.size() == n) begin
      for (int i = 1; i < n; i++)
        check_output({tag, "_spacing"}, 32'(wr_cycles[i] - wr_cycles[i-1]), 32'(gap));
    end
  endtask

  // Watchdog so a stuck run still terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] prog [3];
    prog[0] = 32'h2008_0005;
    prog[1] = 32'h2009_0007;
    prog[2] = 32'h0109_5020;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; fin = 1'b0; next_addr = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset values.
    check_output("rst_in_ready", 32'(in_ready), 32'd0);
    check_output("rst_pcclr",    32'(pcclr),    32'd0);
    check_output("rst_wr_en",    32'(wr_en),    32'd0);
    check_output("rst_wr_addr",  32'(wr_addr),  32'd0);
    check_output("rst_wr_data",  wr_data,       32'd0);
    check_output("rst_done",     32'(done),     32'd0);
    check_output("rst_err",      32'(err),      32'd0);
    rst = 1'b0;
    tick();
    check_output("ready_after_rst", 32'(in_ready), 32'd1);

    // N=3, continuous stream.
    wr_cycles.delete();
    send_header(16'd3, 1'b0);
    for (int i = 0; i < 3; i++) send_word(prog[i], 1'b0);
    in_valid = 1'b0;
    check_output("pcclr_during_last_write", 32'(pcclr), 32'd0);
    check_output("in_ready_after_last",     32'(in_ready), 32'd0);
    tick();
    check_output("pcclr_after_load", 32'(pcclr), 32'd1);
    check_output("wr_en_low_after",  32'(wr_en), 32'd0);
    check_output("scoreboard_empty_1", 32'(exp_q.size()), 32'd0);
    check_gaps("cont", 3, 4);

    // fin rising edge sets done one cycle later.
    fin = 1'b1;
    tick();
    check_output("done_after_fin", 32'(done), 32'd1);
    check_output("pcclr_in_done",  32'(pcclr), 32'd1);
    check_output("ready_in_done",  32'(in_ready), 32'd1);
    fin = 1'b0;
    tick();

    // Same image reloaded with in_valid toggling every other cycle.
    wr_cycles.delete();
    apply_stimulus(8'h00);
    check_output("pcclr_drop_first_byte", 32'(pcclr), 32'd0);
    check_output("done_drop_first_byte",  32'(done), 32'd0);
    idle_gap();
    apply_stimulus(8'h03);
    idle_gap();
    next_addr = '0;
    for (int i = 0; i < 3; i++) send_word(prog[i], 1'b1);
    check_output("pcclr_after_slow_load", 32'(pcclr), 32'd1);
    check_output("scoreboard_empty_2", 32'(exp_q.size()), 32'd0);
    check_gaps("slow", 3, 8);

    // Finish, then a 1-word image; fin during the load is ignored.
    fin = 1'b1; tick(); fin = 1'b0; tick();
    check_output("done_before_reload", 32'(done), 32'd1);
    apply_stimulus(8'h00);
    check_output("pcclr_drop_reload", 32'(pcclr), 32'd0);
    check_output("done_drop_reload",  32'(done), 32'd0);
    idle_gap();
    fin = 1'b1; tick(); fin = 1'b0; tick();
    check_output("fin_ignored_in_load", 32'(done), 32'd0);
    apply_stimulus(8'h01);
    next_addr = '0;
    send_word(32'hAABB_CCDD, 1'b0);
    in_valid = 1'b0;
    tick();
    check_output("pcclr_after_1word", 32'(pcclr), 32'd1);
    check_output("done_after_1word",  32'(done), 32'd0);

    // N=0: no writes, CPU released right away.
    pulse_reset();
    wr_cycles.delete();
    send_header(16'd0, 1'b0);
    in_valid = 1'b0;
    check_output("n0_in_ready", 32'(in_ready), 32'd0);
    check_output("n0_wr_en",    32'(wr_en), 32'd0);
    tick();
    check_output("n0_pcclr", 32'(pcclr), 32'd1);
    tick();
    check_output("n0_no_writes", 32'(wr_cycles.size()), 32'd0);

    // Reset in the middle of an N=2 load, then a full reload.
    pulse_reset();
    send_header(16'd2, 1'b0);
    send_word(32'h1122_3344, 1'b0);
    apply_stimulus(8'h55);
    apply_stimulus(8'h66);
    rst = 1'b1;
    #1;
    check_output("midrst_wr_data",  wr_data, 32'd0);
    check_output("midrst_wr_en",    32'(wr_en), 32'd0);
    check_output("midrst_in_ready", 32'(in_ready), 32'd0);
    check_output("midrst_pcclr",    32'(pcclr), 32'd0);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    send_header(16'd2, 1'b0);
    send_word(32'hDEAD_BEEF, 1'b0);
    send_word(32'h0BAD_F00D, 1'b0);
    in_valid = 1'b0;
    tick();
    check_output("reload_pcclr", 32'(pcclr), 32'd1);
    check_output("scoreboard_empty_3", 32'(exp_q.size()), 32'd0);

    // N = 2^ADDR_W exactly is legal and fills the whole memory.
    pulse_reset();
    send_header(16'h0100, 1'b0);
    for (int i = 0; i < 256; i++)
      send_word({8'(i), 8'(~i), 16'hC0DE}, 1'b0);
    in_valid = 1'b0;
    tick();
    check_output("full_pcclr", 32'(pcclr), 32'd1);
    check_output("full_err",   32'(err), 32'd0);
    check_output("scoreboard_empty_4", 32'(exp_q.size()), 32'd0);

    // N = 2^ADDR_W + 1 is rejected and latches err until reset.
    pulse_reset();
    send_header(16'h0101, 1'b0);
    in_valid = 1'b0;
    check_output("err_set",      32'(err), 32'd1);
    check_output("err_in_ready", 32'(in_ready), 32'd0);
    check_output("err_pcclr",    32'(pcclr), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h77;
    repeat (5) tick();
    check_output("err_sticky",         32'(err), 32'd1);
    check_output("err_in_ready_hold",  32'(in_ready), 32'd0);
    check_output("err_pcclr_hold",     32'(pcclr), 32'd0);
    check_output("err_no_write",       32'(wr_en), 32'd0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_output("err_cleared_by_rst", 32'(err), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check_output("ready_after_err_rst", 32'(in_ready), 32'd1);
    check_output("pcclr_after_err_rst", 32'(pcclr), 32'd0);

    check_output("scoreboard_final", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
